store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 34 +++
 rtl/store_buffer.sv | 99 +++++++++
 tb/tb_store_buffer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer bus: store-select request, data-memory write port, and load-forwarding lookup.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_addr;
  logic [3:0]    in_we;
  logic [31:0]   in_din;

  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_we;
  logic [31:0]   mem_din;

  logic [31:0]   ld_addr;
  logic [31:0]   ld_data;
  logic [3:0]    ld_mask;

  logic [CW-1:0] count;

  modport master (
    output in_valid, in_addr, in_we, in_din, mem_ready, ld_addr,
    input  in_ready, mem_valid, mem_addr, mem_we, mem_din, ld_data, ld_mask, count
  );

  modport slave (
    input  in_valid, in_addr, in_we, in_din, mem_ready, ld_addr,
    output in_ready, mem_valid, mem_addr, mem_we, mem_din, ld_data, ld_mask, count
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer with newest-entry write merging and per-byte load forwarding.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]   addr_q [DEPTH];
  logic [3:0]    we_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [PW-1:0] head_q, tail_q, newest;
  logic [CW-1:0] count_q;
  logic          empty, full, pop, accept, merge, alloc;

  logic [PW-1:0] fwd_idx;
  logic [3:0]    fwd_mask;
  logic [31:0]   fwd_data;
  logic          unused_low_bits;

  assign unused_low_bits = ^{bus.in_addr[1:0], bus.ld_addr[1:0]};

  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == CW'(DEPTH));
    newest = tail_q - PW'(1);
    pop    = !empty && bus.mem_ready;
    accept = bus.in_valid && !full && (bus.in_we != '0);
    // With a single entry the newest is the head; merging into it while it pops would lose the bytes.
    merge  = accept && !empty && (addr_q[newest] == bus.in_addr[31:2])
             && !(pop && (count_q == CW'(1)));
    alloc  = accept && !merge;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop)   head_q <= head_q + PW'(1);
      if (alloc) tail_q <= tail_q + PW'(1);
      case ({alloc, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload is not reset; every consumer is qualified by count.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= bus.in_addr[31:2];
      we_q[tail_q]   <= bus.in_we;
      data_q[tail_q] <= bus.in_din;
    end else if (merge) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.in_we[i]) begin
          we_q[newest][i]         <= 1'b1;
          data_q[newest][8*i +: 8] <= bus.in_din[8*i +: 8];
        end
      end
    end
  end

  // Walk oldest to youngest so younger matches overwrite older bytes.
  always_comb begin
    fwd_idx  = '0;
    fwd_mask = '0;
    fwd_data = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      fwd_idx = head_q + PW'(j);
      if ((CW'(j) < count_q) && (addr_q[fwd_idx] == bus.ld_addr[31:2])) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (we_q[fwd_idx][i]) begin
            fwd_mask[i]          = 1'b1;
            fwd_data[8*i +: 8]   = data_q[fwd_idx][8*i +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    bus.in_ready  = !full;
    bus.mem_valid = !empty;
    bus.mem_addr  = empty ? '0 : {addr_q[head_q], 2'b00};
    bus.mem_we    = empty ? '0 : we_q[head_q];
    bus.mem_din   = empty ? '0 : data_q[head_q];
    bus.ld_mask   = fwd_mask;
    bus.ld_data   = fwd_data;
    bus.count     = count_q;
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed stimulus for store_buffer; memory writes are checked by a scoreboard monitor.
module tb_store_buffer;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];

  store_buffer_if #(.DEPTH(4)) bus ();
  store_buffer #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_we    = we;
    bus.in_din   = d;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_we    = 4'b0000;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    exp_q.push_back('{addr: a, we: we, din: d});
  endtask

  task automatic drain();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 20 && bus.count != 0; i++) step();
    check("drain_count", 32'(bus.count), 32'd0);
    bus.mem_ready = 1'b0;
  endtask

  // Monitor: every accepted memory write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.mem_valid && bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("mem_addr", bus.mem_addr, e.addr);
        check("mem_we", 32'(bus.mem_we), 32'(e.we));
        check("mem_din", bus.mem_din, e.din);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_we     = '0;
    bus.in_din    = '0;
    bus.mem_ready = 1'b0;
    bus.ld_addr   = '0;
    rst           = 1'b0;
    step();
    step();
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ld_mask", 32'(bus.ld_mask), 32'd0);
    check("rst_ld_data", bus.ld_data, 32'd0);
    rst = 1'b1;
    step();

    // Single store, memory always ready
    bus.mem_ready = 1'b1;
    expect_wr(32'h100, 4'b0001, 32'h0000_00AB);
    drive(32'h100, 4'b0001, 32'h0000_00AB);
    step();
    idle();
    check("single_valid", 32'(bus.mem_valid), 32'd1);
    check("single_count", 32'(bus.count), 32'd1);
    step();
    check("single_count_after", 32'(bus.count), 32'd0);
    bus.mem_ready = 1'b0;

    // Merge into newest entry
    drive(32'h200, 4'b0011, 32'h0000_1234);
    step();
    drive(32'h202, 4'b1100, 32'h5678_0000);
    step();
    idle();
    check("merge_count", 32'(bus.count), 32'd1);
    check("merge_we", 32'(bus.mem_we), 32'hF);
    check("merge_din", bus.mem_din, 32'h5678_1234);
    expect_wr(32'h200, 4'b1111, 32'h5678_1234);
    drain();

    // Zero byte-enable store is swallowed
    drive(32'h500, 4'b0000, 32'h1111_1111);
    step();
    idle();
    check("zero_we_count", 32'(bus.count), 32'd0);

    // Fill, back-pressure, wrap
    for (int k = 0; k < 4; k++) begin
      expect_wr(32'h10 * (k + 1), 4'b1111, 32'hA000_0000 + k);
      drive(32'h10 * (k + 1), 4'b1111, 32'hA000_0000 + k);
      step();
    end
    drive(32'h50, 4'b1111, 32'hA000_0004);
    expect_wr(32'h50, 4'b1111, 32'hA000_0004);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("held_count", 32'(bus.count), 32'd4);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    check("one_pop_count", 32'(bus.count), 32'd3);
    check("one_pop_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    idle();
    check("fifth_accepted", 32'(bus.count), 32'd4);
    drain();

    // Forwarding with youngest-wins priority
    expect_wr(32'h300, 4'b0101, 32'h00AA_0011);
    drive(32'h300, 4'b0101, 32'h00AA_0011);
    step();
    expect_wr(32'h308, 4'b1111, 32'hDEAD_BEEF);
    drive(32'h308, 4'b1111, 32'hDEAD_BEEF);
    step();
    expect_wr(32'h300, 4'b0011, 32'h0000_2222);
    drive(32'h300, 4'b0011, 32'h0000_2222);
    step();
    idle();
    bus.ld_addr = 32'h301;
    #1;
    check("fwd_mask", 32'(bus.ld_mask), 32'h7);
    check("fwd_data", bus.ld_data, 32'h00AA_2222);
    bus.ld_addr = 32'h304;
    #1;
    check("fwd_miss_mask", 32'(bus.ld_mask), 32'h0);
    check("fwd_miss_data", bus.ld_data, 32'h0);
    bus.ld_addr = 32'h30C;
    expect_wr(32'h30C, 4'b1111, 32'hCAFE_F00D);
    drive(32'h30C, 4'b1111, 32'hCAFE_F00D);
    #1;
    check("fwd_same_cycle_mask", 32'(bus.ld_mask), 32'h0);
    step();
    idle();
    check("fwd_new_mask", 32'(bus.ld_mask), 32'hF);
    check("fwd_new_data", bus.ld_data, 32'hCAFE_F00D);
    drain();

    // Store to head address while head pops: no merge
    expect_wr(32'h400, 4'b0001, 32'h0000_0001);
    drive(32'h400, 4'b0001, 32'h0000_0001);
    step();
    bus.mem_ready = 1'b1;
    expect_wr(32'h400, 4'b0010, 32'h0000_0200);
    drive(32'h400, 4'b0010, 32'h0000_0200);
    step();
    idle();
    check("simul_count", 32'(bus.count), 32'd1);
    check("simul_head_we", 32'(bus.mem_we), 32'h2);
    step();
    check("simul_count_after", 32'(bus.count), 32'd0);
    bus.mem_ready = 1'b0;

    // Reset mid-drain discards pending stores
    for (int k = 0; k < 3; k++) begin
      drive(32'h600 + 32'(4 * k), 4'b1111, 32'hBAD0_0000 + k);
      step();
    end
    idle();
    check("pre_rst_count", 32'(bus.count), 32'd3);
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.mem_valid), 32'd0);
    check("async_rst_count", 32'(bus.count), 32'd0);
    bus.mem_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("post_rst_valid", 32'(bus.mem_valid), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
